// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_DATA  = 1'b0,
        OWNER_FETCH = 1'b1
    } owner_e;

    // Everything presented to memory for one transaction, latched at grant.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        extend;
        logic [1:0]  width;
    } mem_cmd_t;

    // A zero limit still needs a one-bit counter to keep the vector legal.
    function automatic int starve_cnt_w(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of the fetch requester, data requester and memory-port signals.
// slave = arbiter view; master = requesters plus memory model view.
interface mem_arbiter_if;

    logic        fe_req;
    logic [31:0] fe_addr;
    logic        fe_ack;
    logic [31:0] fe_data;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic        mem_ack;
    logic [31:0] mem_data_in;

    logic        memory_req;
    logic [31:0] memory_addr;
    logic        memory_write;
    logic [31:0] memory_data_in;
    logic        memory_extend;
    logic [1:0]  memory_width;
    logic        memory_ack;
    logic [31:0] memory_data_out;

    modport slave (
        input  fe_req, fe_addr,
        input  mem_req, mem_addr, mem_write, mem_data_out, mem_extend, mem_width,
        input  memory_ack, memory_data_out,
        output fe_ack, fe_data, mem_ack, mem_data_in,
        output memory_req, memory_addr, memory_write, memory_data_in,
        output memory_extend, memory_width
    );

    modport master (
        output fe_req, fe_addr,
        output mem_req, mem_addr, mem_write, mem_data_out, mem_extend, mem_width,
        output memory_ack, memory_data_out,
        input  fe_ack, fe_data, mem_ack, mem_data_in,
        input  memory_req, memory_addr, memory_write, memory_data_in,
        input  memory_extend, memory_width
    );

endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Purpose: share one memory port between fetch and data; data wins, starve counter forces fetch.
// Latency: req -> memory_req 1 cycle; memory_ack -> owner ack 1 cycle; k+3 cycles per transaction.
// Backpressure: requesters hold req until their ack; memory holds off by delaying memory_ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam int                CNT_W   = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             memory_req_q, memory_req_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             fe_ack_q, fe_ack_d;
    logic             mem_ack_q, mem_ack_d;
    logic [31:0]      fe_data_q, fe_data_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;

    logic             starve_hit;
    logic             fetch_wins;
    logic [CNT_W-1:0] starve_inc;
    mem_cmd_t         fetch_cmd;
    mem_cmd_t         data_cmd;

    assign starve_hit = (STARVE_LIMIT != 0) && (starve_q == CNT_MAX);
    assign fetch_wins = bus.fe_req && (!bus.mem_req || starve_hit);
    assign starve_inc = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);

    // Fetch is always a plain word read, so store/extend fields are forced quiet.
    assign fetch_cmd = '{addr: bus.fe_addr, write: 1'b0, wdata: 32'd0,
                         extend: 1'b0, width: WIDTH_W};
    assign data_cmd  = '{addr: bus.mem_addr, write: bus.mem_write, wdata: bus.mem_data_out,
                         extend: bus.mem_extend, width: bus.mem_width};

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        memory_req_d = memory_req_q;
        cmd_d        = cmd_q;
        fe_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        fe_data_d    = fe_data_q;
        mem_rdata_d  = mem_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.fe_req || bus.mem_req) begin
                    memory_req_d = 1'b1;
                    state_d      = ST_BUSY;
                    if (fetch_wins) begin
                        owner_d  = OWNER_FETCH;
                        cmd_d    = fetch_cmd;
                        starve_d = '0;
                    end else begin
                        owner_d  = OWNER_DATA;
                        cmd_d    = data_cmd;
                        starve_d = bus.fe_req ? starve_inc : '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.memory_ack) begin
                    memory_req_d = 1'b0;
                    state_d      = ST_RELEASE;
                    if (owner_q == OWNER_FETCH) begin
                        fe_ack_d  = 1'b1;
                        fe_data_d = bus.memory_data_out;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = bus.memory_data_out;
                    end
                end
            end
            // Dead cycle: requester sees its ack and may drop req before the next grant.
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_DATA;
            starve_q     <= '0;
            memory_req_q <= 1'b0;
            cmd_q        <= '0;
            fe_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            fe_data_q    <= 32'd0;
            mem_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            memory_req_q <= memory_req_d;
            cmd_q        <= cmd_d;
            fe_ack_q     <= fe_ack_d;
            mem_ack_q    <= mem_ack_d;
            fe_data_q    <= fe_data_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign bus.memory_req     = memory_req_q;
    assign bus.memory_addr    = cmd_q.addr;
    assign bus.memory_write   = cmd_q.write;
    assign bus.memory_data_in = cmd_q.wdata;
    assign bus.memory_extend  = cmd_q.extend;
    assign bus.memory_width   = cmd_q.width;
    assign bus.fe_ack         = fe_ack_q;
    assign bus.fe_data        = fe_data_q;
    assign bus.mem_ack        = mem_ack_q;
    assign bus.mem_data_in    = mem_rdata_q;

    a_ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(fe_ack_q && mem_ack_q));

    a_req_means_busy: assert property (@(posedge clk) disable iff (!reset_n)
        memory_req_q == (state_q == ST_BUSY));

    a_cmd_frozen: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q != ST_IDLE) |=> $stable(cmd_q));

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Random requesters and memory checked against a transaction-level arbitration model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus  ();
    mem_arbiter_if bus0 ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    mem_arbiter #(.STARVE_LIMIT(0))     dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

    int n_pass  = 0;
    int n_total = 0;

    // model state
    int          cyc          = 0;
    int          next_grant   = 0;
    int          starve       = 0;
    int          lat          = 0;
    bit          outstanding  = 1'b0;
    bit          own_fetch    = 1'b0;
    logic [31:0] exp_addr     = '0;
    logic [31:0] exp_wdata    = '0;
    logic        exp_write    = 1'b0;
    logic        exp_ext      = 1'b0;
    logic [1:0]  exp_width    = 2'b00;
    logic [31:0] exp_fe_data  = '0;
    logic [31:0] exp_mem_data = '0;

    int p_fe, p_mem, p_reissue, p_spur, p_drop;
    bit want_reset   = 1'b0;
    bit did_reset    = 1'b0;
    int forced_fetch = 0;
    int fetch_grants = 0;
    int data_grants  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic new_fetch();
        bus.fe_req  = 1'b1;
        bus.fe_addr = $urandom() & 32'hFFFF_FFFC;
    endtask

    task automatic new_data();
        bus.mem_req      = 1'b1;
        bus.mem_addr     = $urandom();
        bus.mem_write    = 1'($urandom_range(0, 1));
        bus.mem_data_out = $urandom();
        bus.mem_extend   = 1'($urandom_range(0, 1));
        bus.mem_width    = 2'($urandom_range(0, 2));
    endtask

    task automatic drive();
        bus.memory_ack = 1'b0;
        if (outstanding) begin
            if (lat == 0) begin
                bus.memory_ack      = 1'b1;
                bus.memory_data_out = $urandom();
            end else begin
                lat--;
            end
        end else if ($urandom_range(0, 99) < p_spur) begin
            bus.memory_ack      = 1'b1;
            bus.memory_data_out = $urandom();
        end

        if (bus.fe_req) begin
            if (bus.fe_ack) begin
                if ($urandom_range(0, 99) < p_reissue) new_fetch();
                else bus.fe_req = 1'b0;
            end else if (outstanding && $urandom_range(0, 99) < p_drop) begin
                bus.fe_req = 1'b0;
            end else if (outstanding) begin
                bus.fe_addr = $urandom() & 32'hFFFF_FFFC;
            end
        end else if ($urandom_range(0, 99) < p_fe) begin
            new_fetch();
        end

        if (bus.mem_req) begin
            if (bus.mem_ack) begin
                if ($urandom_range(0, 99) < p_reissue) new_data();
                else bus.mem_req = 1'b0;
            end else if (outstanding && $urandom_range(0, 99) < p_drop) begin
                bus.mem_req = 1'b0;
            end else if (outstanding) begin
                bus.mem_addr     = $urandom();
                bus.mem_data_out = $urandom();
                bus.mem_write    = ~bus.mem_write;
                bus.mem_extend   = ~bus.mem_extend;
            end
        end else if ($urandom_range(0, 99) < p_mem) begin
            new_data();
        end
    endtask

    task automatic step();
        bit efa, ema, fe_win;
        @(posedge clk);
        #1;
        cyc++;
        efa = 1'b0;
        ema = 1'b0;
        if (outstanding) begin
            if (bus.memory_ack) begin
                outstanding = 1'b0;
                next_grant  = cyc + 2;
                if (own_fetch) begin
                    efa         = 1'b1;
                    exp_fe_data = bus.memory_data_out;
                end else begin
                    ema          = 1'b1;
                    exp_mem_data = bus.memory_data_out;
                end
            end
        end else if (cyc >= next_grant && (bus.fe_req || bus.mem_req)) begin
            fe_win = bus.fe_req && (!bus.mem_req || (LIMIT != 0 && starve >= LIMIT));
            if (fe_win) begin
                own_fetch = 1'b1;
                exp_addr  = bus.fe_addr;
                exp_write = 1'b0;
                exp_wdata = 32'd0;
                exp_ext   = 1'b0;
                exp_width = WIDTH_W;
                starve    = 0;
                fetch_grants++;
                if (bus.mem_req) forced_fetch++;
            end else begin
                own_fetch = 1'b0;
                exp_addr  = bus.mem_addr;
                exp_write = bus.mem_write;
                exp_wdata = bus.mem_data_out;
                exp_ext   = bus.mem_extend;
                exp_width = bus.mem_width;
                starve    = bus.fe_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                data_grants++;
            end
            outstanding = 1'b1;
            lat         = $urandom_range(0, 3);
        end

        chk("memory_req", 32'(bus.memory_req), 32'(outstanding));
        if (outstanding) begin
            chk("memory_addr",    bus.memory_addr,           exp_addr);
            chk("memory_write",   32'(bus.memory_write),     32'(exp_write));
            chk("memory_data_in", bus.memory_data_in,        exp_wdata);
            chk("memory_extend",  32'(bus.memory_extend),    32'(exp_ext));
            chk("memory_width",   32'(bus.memory_width),     32'(exp_width));
        end
        chk("fe_ack",      32'(bus.fe_ack),  32'(efa));
        chk("mem_ack",     32'(bus.mem_ack), 32'(ema));
        chk("fe_data",     bus.fe_data,      exp_fe_data);
        chk("mem_data_in", bus.mem_data_in,  exp_mem_data);

        drive();

        if (want_reset && outstanding) begin
            #3 reset_n = 1'b0;
            #1;
            chk("rst_memory_req", 32'(bus.memory_req), 32'd0);
            chk("rst_fe_ack",     32'(bus.fe_ack),     32'd0);
            chk("rst_mem_ack",    32'(bus.mem_ack),    32'd0);
            chk("rst_memory_addr", bus.memory_addr,    32'd0);
            chk("rst_fe_data",    bus.fe_data,         32'd0);
            bus.memory_ack = 1'b0;
            outstanding    = 1'b0;
            starve         = 0;
            exp_fe_data    = 32'd0;
            exp_mem_data   = 32'd0;
            #2 reset_n = 1'b1;
            next_grant = cyc + 1;
            want_reset = 1'b0;
            did_reset  = 1'b1;
        end
    endtask

    int          nd0, nf_early, nf_late, nd0_at_fetch;
    bit          prev0;
    logic [31:0] fe0_data;

    initial begin
        bus.fe_req = 1'b0;  bus.fe_addr = '0;
        bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_write = 1'b0;
        bus.mem_data_out = '0; bus.mem_extend = 1'b0; bus.mem_width = 2'b00;
        bus.memory_ack = 1'b0; bus.memory_data_out = '0;
        bus0.fe_req = 1'b0;  bus0.fe_addr = '0;
        bus0.mem_req = 1'b0; bus0.mem_addr = '0; bus0.mem_write = 1'b0;
        bus0.mem_data_out = '0; bus0.mem_extend = 1'b0; bus0.mem_width = 2'b00;
        bus0.memory_ack = 1'b0; bus0.memory_data_out = '0;

        #3;
        chk("reset_memory_req",  32'(bus.memory_req),   32'd0);
        chk("reset_fe_ack",      32'(bus.fe_ack),       32'd0);
        chk("reset_mem_ack",     32'(bus.mem_ack),      32'd0);
        chk("reset_memory_addr", bus.memory_addr,       32'd0);
        chk("reset_memory_width", 32'(bus.memory_width), 32'd0);
        chk("reset_fe_data",     bus.fe_data,           32'd0);
        chk("reset_mem_data_in", bus.mem_data_in,       32'd0);
        chk("reset_l0_memory_req", 32'(bus0.memory_req), 32'd0);
        #9 reset_n = 1'b1;

        // fetch only
        p_fe = 100; p_mem = 0; p_reissue = 0; p_spur = 0; p_drop = 0;
        repeat (30) step();
        // both requesters saturating the port: starvation forcing must kick in
        p_fe = 100; p_mem = 100; p_reissue = 100; p_spur = 0; p_drop = 0;
        repeat (200) step();
        // mixed traffic with spurious acks and occasional requester drops
        p_fe = 40; p_mem = 40; p_reissue = 50; p_spur = 15; p_drop = 3;
        repeat (400) step();
        want_reset = 1'b1;
        repeat (400) step();

        chk("reset_mid_busy_hit", 32'(did_reset), 32'd1);
        chk("forced_fetch_seen",  32'(forced_fetch > 0), 32'd1);
        chk("fetch_grants_seen",  32'(fetch_grants > 0), 32'd1);
        chk("data_grants_seen",   32'(data_grants > 0), 32'd1);

        // strict data priority: fetch waits until the data requester lets go
        bus.fe_req = 1'b0; bus.mem_req = 1'b0; bus.memory_ack = 1'b0;
        bus0.mem_req = 1'b1; bus0.mem_write = 1'b1; bus0.mem_addr = 32'h40;
        bus0.mem_data_out = 32'hDEADBEEF; bus0.mem_width = WIDTH_W; bus0.mem_extend = 1'b0;
        bus0.fe_req = 1'b1; bus0.fe_addr = 32'h100;
        bus0.memory_data_out = 32'h0000_0013;
        nd0 = 0; nf_early = 0; nf_late = 0; nd0_at_fetch = -1; prev0 = 1'b0; fe0_data = '0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("l0_ack_exclusive", 32'(bus0.fe_ack && bus0.mem_ack), 32'd0);
            if (bus0.memory_req && !prev0) begin
                if (bus0.memory_write) begin
                    nd0++;
                    if (nd0 == 1) begin
                        chk("l0_store_addr", bus0.memory_addr,    32'h40);
                        chk("l0_store_data", bus0.memory_data_in, 32'hDEADBEEF);
                    end
                end else begin
                    if (bus0.mem_req) nf_early++;
                    else nf_late++;
                    nd0_at_fetch = nd0;
                    chk("l0_fetch_width", 32'(bus0.memory_width),   32'(WIDTH_W));
                    chk("l0_fetch_wdata", bus0.memory_data_in,      32'd0);
                    chk("l0_fetch_addr",  bus0.memory_addr,         32'h100);
                end
            end
            prev0 = bus0.memory_req;
            bus0.memory_ack = bus0.memory_req;
            if (bus0.mem_ack && nd0 >= 6) bus0.mem_req = 1'b0;
            if (bus0.fe_ack) begin
                bus0.fe_req = 1'b0;
                fe0_data    = bus0.fe_data;
            end
        end
        chk("l0_data_grants",      32'(nd0),          32'd6);
        chk("l0_fetch_while_data", 32'(nf_early),     32'd0);
        chk("l0_fetch_after_drop", 32'(nf_late),      32'd1);
        chk("l0_fetch_order",      32'(nd0_at_fetch), 32'd6);
        chk("l0_fe_data",          fe0_data,          32'h0000_0013);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
